// File: rtl/pipe_skid_buffer.sv
// Elastic valid/ready pipeline register with one-beat skid storage.
// Breaks the combinational stall path: in_ready, out_valid and count are all flop outputs.
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_ready_q;
    logic             out_valid_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Any beat handshaken this cycle is killed; data registers keep stale contents.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Handshake flags are registered copies decoded from the next state.
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed scenarios plus a random soak,
// all checked against a FIFO-of-beats reference model (queue holding 0..2 beats).
module tb_pipe_skid_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  count;

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] held_q[$];
    bit          data_zero = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, held_q.size() != 0});
        chk("count", {30'd0, count}, held_q.size());
        chk("in_ready", {31'd0, in_ready}, {31'd0, held_q.size() != 2});
        if (held_q.size() != 0)
            chk("out_data", out_data, held_q[0]);
        else if (data_zero)
            chk("out_data_rst", out_data, 32'd0);
    endtask

    // One clock cycle: check outputs, drive inputs, then advance the reference model.
    task automatic do_cycle(input logic rn, input logic f, input logic v,
                            input logic [31:0] d, input logic r);
        bit up, dn;
        @(negedge clk);
        check_outputs();
        rst_n = rn; flush = f; in_valid = v; in_data = d; out_ready = r;
        up = v && (held_q.size() != 2);
        dn = r && (held_q.size() != 0);
        @(posedge clk);
        if (!rn) begin
            held_q.delete();
            data_zero = 1'b1;
        end else begin
            if (dn) void'(held_q.pop_front());
            if (f) begin
                held_q.delete();
            end else if (up) begin
                held_q.push_back(d);
                data_zero = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset with junk upstream traffic
        do_cycle(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

        // Streaming at full rate
        do_cycle(1'b1, 1'b0, 1'b1, 32'h1, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b1, 32'h2, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b1, 32'h3, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Stall fill: A, B absorbed, C held off, then drained in order
        do_cycle(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush while FULL with a simultaneous upstream beat
        do_cycle(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'hF, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Simultaneous accept in BUSY
        do_cycle(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 32'h6, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Random soak with 5% flush and rare resets
        for (int i = 0; i < 10000; i++) begin
            do_cycle(($urandom_range(999) != 0),
                     ($urandom_range(99) < 5),
                     $urandom_range(1),
                     $urandom(),
                     $urandom_range(1));
        end

        @(negedge clk);
        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
